sc_max7219_chain: RTL and testbench
===================================

# sc_max7219_chain

Parametrised LED-matrix refresh engine for a daisy chain of MAX7219 drivers. It replaces the single-device matrix controller with three additions: N cascaded 8x8 devices, a snapshot framebuffer, and run-time intensity updates. After reset it runs the MAX7219 init sequence, then refreshes all digit registers continuously from a flat frame bus. It sits between the game registers and the matrix pins at the bottom of the system block.

## Interface
- N_DEV, 1: number of cascaded MAX7219 devices (1..8).
- CLK_DIV, 4: half-period of the serial clock, in system clocks (≥1).
- SCAN_LIMIT, 3'd7: value written to register 0x0B.
- SC_MAX7219CHAIN_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SC_MAX7219CHAIN_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_MAX7219CHAIN_frame_InBUS  in  64*N_DEV  device d, row r = bits [64d+8r +: 8], with bit 7 as the leftmost pixel.
- SC_MAX7219CHAIN_intensity_InBUS  in  4  brightness value for register 0x0A.
- SC_MAX7219CHAIN_din_Out  out  1  serial data (max7219_din).
- SC_MAX7219CHAIN_ncs_Out  out  1  chip select, active low.
- SC_MAX7219CHAIN_clk_Out  out  1  serial clock; idles low.
- SC_MAX7219CHAIN_initDone_Out  out  1  high once the init sequence has completed.
- SC_MAX7219CHAIN_frameDone_Out  out  1  one-cycle pulse at the end of each refresh pass.

## Operation
- Transaction: ncs low, then 16*N_DEV bits shifted MSB first, then ncs high. Each device word is {addr[7:0], data[7:0]}.
  - Device N_DEV-1's word is shifted first; device 0 (nearest the FPGA) is shifted last.
- States: INIT → REFRESH → (INTEN) → REFRESH …
- INIT: five transactions, each sending the same word to every device, in this order:
  - 0x0C01 (normal operation)
  - 0x0F00 (display test off)
  - 0x0900 (no decode)
  - 0x0B,SCAN_LIMIT
  - 0x0A,intensity
- After INIT, initDone rises and stays high until reset.
- REFRESH, pass start: the full frame bus is latched into an internal snapshot. Frame changes during a pass never affect that pass.
- REFRESH, pass body: eight transactions, digit address 0x01..0x08. For digit k = r+1, device d receives snapshot row r of device d.
- REFRESH, pass end: frameDone pulses on the cycle ncs rises after digit 0x08.
- Intensity update:
  - Intensity is sampled only at pass end.
  - If the sampled value differs from the last value sent, state INTEN sends one 0x0A transaction to all devices, then the next pass starts.
  - Otherwise the next pass starts immediately.
- Reset asserted at any point, including mid-transaction, aborts everything. After release the block restarts at INIT.

## Timing
- Reset values:
  - din = 0, ncs = 1, clk = 0.
  - initDone = 0, frameDone = 0.
  - Snapshot = 0; last-sent intensity = 0.
- INIT begins on the first clock after reset release, with ncs falling that cycle.
- Bit timing: din changes only while clk is low. clk is low for CLK_DIV cycles, then high for CLK_DIV cycles, so each bit lasts 2*CLK_DIV cycles and the MAX7219 samples on the rising clk edge.
- End of transaction: on the cycle the last high phase ends, clk returns low and ncs rises together. ncs then stays high for exactly CLK_DIV cycles before the next transaction.
- Transaction period: (32*N_DEV+1)*CLK_DIV cycles.
- Refresh pass: 8 × that period (9 × when INTEN runs).
- CLK_DIV=1 is legal: clk toggles every cycle.
- Intensity changing within a pass: only the value present at pass end is sent. Intermediate values are never sent.

## Configuration
- SC_MAX7219CHAIN_TRANSPOSE_EN defined: each device's digit data is column-transposed for matrices mounted rotated 90°. Digit k = 8-c carries {row0[c], row1[c], …, row7[c]} of that device, for c = 7..0, so digit 1 holds column bit 7.
- Undefined: digit r+1 carries row r unchanged.
- Only the data mux changes. Timing and sequencing are identical in both builds.

## Test plan
- Reset release, N_DEV=2, CLK_DIV=2, intensity=4'hA → 5 INIT transactions decoded as 0x0C01, 0x0F00, 0x0900, 0x0B07, 0x0A0A, each repeated twice per frame. ncs low 128 cycles per transaction, high 2 cycles between transactions. initDone rises after the 5th.
- Frame with device1 row0=0x81, device0 row0=0x3C, rest 0 → digit-1 transaction shifts 0x0181 then 0x013C. frameDone pulses once after digit 8.
- Frame bus changed mid-pass → the current pass shows only old data; the next pass shows new data.
- Intensity 0xA→0x3 mid-pass, then 0x3→0x5→0x3 within the following pass → exactly one 0x0A03 transaction after the first pass end; none after the second.
- Reset asserted during bit 9 of a transaction → same cycle ncs=1, clk=0, din=0, initDone=0. After release the 0x0C01 transaction restarts.
- TRANSPOSE_EN build, N_DEV=1, rows 0..7 = 0x80,0,0,0,0,0,0,0 → digit 1 = 0x80, digits 2..8 = 0x00. Without the macro, digit 1 = 0x80 and the rest = 0x00. Also check row0=0x01 → transposed digit 8 = 0x80.

Source files
------------

// File: rtl/sc_max7219_chain.sv
// Refresh engine for a daisy chain of N_DEV MAX7219 8x8 drivers: init sequence, snapshot refresh, intensity updates.
// Optional build macro SC_MAX7219CHAIN_TRANSPOSE_EN column-transposes digit data for 90-degree rotated matrices.
module sc_max7219_chain #(
    parameter int         N_DEV      = 1,
    parameter int         CLK_DIV    = 4,
    parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
    input  logic                 SC_MAX7219CHAIN_CLOCK_50,
    input  logic                 SC_MAX7219CHAIN_RESET_InHigh,
    input  logic [64*N_DEV-1:0]  SC_MAX7219CHAIN_frame_InBUS,
    input  logic [3:0]           SC_MAX7219CHAIN_intensity_InBUS,
    output logic                 SC_MAX7219CHAIN_din_Out,
    output logic                 SC_MAX7219CHAIN_ncs_Out,
    output logic                 SC_MAX7219CHAIN_clk_Out,
    output logic                 SC_MAX7219CHAIN_initDone_Out,
    output logic                 SC_MAX7219CHAIN_frameDone_Out
);

    localparam int SW = 16 * N_DEV;
    localparam int BW = $clog2(SW);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);

    typedef enum logic [1:0] {ST_INIT, ST_REFRESH, ST_INTEN} state_t;
    typedef enum logic [1:0] {PH_GAP, PH_LOW, PH_HIGH} phase_t;

    state_t               state;
    phase_t               phase;
    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [2:0]           step;
    logic [SW-1:0]        shreg;
    logic [64*N_DEV-1:0]  snapshot;
    logic [3:0]           last_int;
    logic                 din;
    logic                 ncs;
    logic                 sclk;
    logic                 init_done;
    logic                 frame_done;

    logic [7:0]           addr;
    logic [7:0]           data_com;
    logic                 per_dev;
    logic [64*N_DEV-1:0]  src;
    logic [SW-1:0]        load;

    // Digit byte for one device: row r as-is, or column 7-r gathered top-to-bottom when transposed.
    function automatic logic [7:0] digit_data(input logic [63:0] dev, input logic [2:0] row);
        logic [7:0] res;
`ifdef SC_MAX7219CHAIN_TRANSPOSE_EN
        logic [2:0] c;
        int         idx;
        c = 3'd7 - row;
        for (int j = 0; j < 8; j++) begin
            idx        = 8 * j + int'(c);
            res[7 - j] = dev[idx];
        end
`else
        res = dev[8 * row +: 8];
`endif
        return res;
    endfunction

    // Word selection for the next transaction; digit 1 reads the live bus because the snapshot loads on that same edge.
    always_comb begin
        addr     = 8'h00;
        data_com = 8'h00;
        per_dev  = 1'b0;
        case (state)
            ST_INIT: begin
                case (step)
                    3'd0:    begin addr = 8'h0C; data_com = 8'h01; end
                    3'd1:    begin addr = 8'h0F; data_com = 8'h00; end
                    3'd2:    begin addr = 8'h09; data_com = 8'h00; end
                    3'd3:    begin addr = 8'h0B; data_com = {5'd0, SCAN_LIMIT}; end
                    3'd4:    begin addr = 8'h0A; data_com = {4'h0, SC_MAX7219CHAIN_intensity_InBUS}; end
                    default: begin addr = 8'h0C; data_com = 8'h01; end
                endcase
            end
            ST_REFRESH: begin
                addr    = {5'd0, step} + 8'd1;
                per_dev = 1'b1;
            end
            ST_INTEN: begin
                addr     = 8'h0A;
                data_com = {4'h0, last_int};
            end
            default: begin
                addr     = 8'h0C;
                data_com = 8'h01;
            end
        endcase
        if (state == ST_REFRESH && step == 3'd0) begin
            src = SC_MAX7219CHAIN_frame_InBUS;
        end else begin
            src = snapshot;
        end
        load = '0;
        for (int d = 0; d < N_DEV; d++) begin
            if (per_dev) begin
                load[16 * d +: 16] = {addr, digit_data(src[64 * d +: 64], step)};
            end else begin
                load[16 * d +: 16] = {addr, data_com};
            end
        end
    end

    // Serial shifter, bit timing and init/refresh/intensity sequencing.
    always_ff @(posedge SC_MAX7219CHAIN_CLOCK_50 or posedge SC_MAX7219CHAIN_RESET_InHigh) begin
        if (SC_MAX7219CHAIN_RESET_InHigh) begin
            state      <= ST_INIT;
            phase      <= PH_GAP;
            div_cnt    <= DIV_LAST;
            bit_cnt    <= '0;
            step       <= 3'd0;
            shreg      <= '0;
            snapshot   <= '0;
            last_int   <= 4'h0;
            din        <= 1'b0;
            ncs        <= 1'b1;
            sclk       <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (phase)
                PH_GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        shreg   <= load;
                        din     <= load[SW-1];
                        ncs     <= 1'b0;
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        phase   <= PH_LOW;
                        if (state == ST_REFRESH && step == 3'd0) begin
                            snapshot <= SC_MAX7219CHAIN_frame_InBUS;
                        end
                        if (state == ST_INIT && step == 3'd4) begin
                            last_int <= SC_MAX7219CHAIN_intensity_InBUS;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                PH_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                        phase   <= PH_HIGH;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                PH_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            ncs   <= 1'b1;
                            din   <= 1'b0;
                            phase <= PH_GAP;
                            case (state)
                                ST_INIT: begin
                                    if (step == 3'd4) begin
                                        state     <= ST_REFRESH;
                                        step      <= 3'd0;
                                        init_done <= 1'b1;
                                    end else begin
                                        step <= step + 3'd1;
                                    end
                                end
                                ST_REFRESH: begin
                                    if (step == 3'd7) begin
                                        frame_done <= 1'b1;
                                        step       <= 3'd0;
                                        if (SC_MAX7219CHAIN_intensity_InBUS != last_int) begin
                                            last_int <= SC_MAX7219CHAIN_intensity_InBUS;
                                            state    <= ST_INTEN;
                                        end else begin
                                            state <= ST_REFRESH;
                                        end
                                    end else begin
                                        step <= step + 3'd1;
                                    end
                                end
                                ST_INTEN: begin
                                    state <= ST_REFRESH;
                                    step  <= 3'd0;
                                end
                                default: begin
                                    state <= ST_INIT;
                                    step  <= 3'd0;
                                end
                            endcase
                        end else begin
                            shreg   <= {shreg[SW-2:0], 1'b0};
                            din     <= shreg[SW-2];
                            bit_cnt <= bit_cnt + BW'(1);
                            phase   <= PH_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    phase   <= PH_GAP;
                    div_cnt <= DIV_LAST;
                end
            endcase
        end
    end

    assign SC_MAX7219CHAIN_din_Out       = din;
    assign SC_MAX7219CHAIN_ncs_Out       = ncs;
    assign SC_MAX7219CHAIN_clk_Out       = sclk;
    assign SC_MAX7219CHAIN_initDone_Out  = init_done;
    assign SC_MAX7219CHAIN_frameDone_Out = frame_done;

endmodule

// File: tb/tb_sc_max7219_chain.sv
// Bench for sc_max7219_chain (N_DEV=2, CLK_DIV=2): decodes the serial bus and compares against a frame/intensity model.
module tb_sc_max7219_chain;

    logic         clk;
    logic         rst;
    logic [127:0] frame;
    logic [3:0]   intensity;
    logic         din;
    logic         ncs;
    logic         sclk;
    logic         init_done;
    logic         frame_done;

    int checks = 0;
    int errors = 0;

    sc_max7219_chain #(.N_DEV(2), .CLK_DIV(2), .SCAN_LIMIT(3'd7)) dut (
        .SC_MAX7219CHAIN_CLOCK_50        (clk),
        .SC_MAX7219CHAIN_RESET_InHigh    (rst),
        .SC_MAX7219CHAIN_frame_InBUS     (frame),
        .SC_MAX7219CHAIN_intensity_InBUS (intensity),
        .SC_MAX7219CHAIN_din_Out         (din),
        .SC_MAX7219CHAIN_ncs_Out         (ncs),
        .SC_MAX7219CHAIN_clk_Out         (sclk),
        .SC_MAX7219CHAIN_initDone_Out    (init_done),
        .SC_MAX7219CHAIN_frameDone_Out   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor state, written only by the monitor process.
    logic [31:0] txq [$];
    int          lowq [$];
    int          bitq [$];
    int          gapq [$];
    logic [31:0] cap;
    int          mon_bits;
    int          low_cnt;
    int          gap_cnt;
    int          fd_cnt = 0;
    int          fd_bad = 0;
    int          viol = 0;
    logic        prev_ncs;
    logic        prev_sclk;
    logic        prev_din;
    logic        seen_first;

    always @(negedge clk) begin
        if (rst) begin
            cap = 32'h0; mon_bits = 0; low_cnt = 0; gap_cnt = 0;
            prev_ncs = 1'b1; prev_sclk = 1'b0; prev_din = 1'b0; seen_first = 1'b0;
        end else begin
            if (!ncs) begin
                if (prev_ncs) begin
                    if (seen_first) gapq.push_back(gap_cnt);
                    cap = 32'h0; mon_bits = 0; low_cnt = 0;
                end
                low_cnt++;
                if (sclk && !prev_sclk) begin
                    cap = {cap[30:0], din};
                    mon_bits++;
                end
                if (sclk && prev_sclk && din !== prev_din) viol++;
            end else begin
                if (!prev_ncs) begin
                    txq.push_back(cap); lowq.push_back(low_cnt); bitq.push_back(mon_bits);
                    gap_cnt = 0; seen_first = 1'b1;
                end
                gap_cnt++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (!(ncs && !prev_ncs)) fd_bad++;
            end
            prev_ncs = ncs; prev_sclk = sclk; prev_din = din;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops one decoded transaction and checks its length and bit count.
    task automatic get_tx(input string tag, output logic [31:0] w);
        int n;
        int lo;
        int bi;
        n = 0;
        while (txq.size() == 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (txq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=none expected=transaction", tag);
            w = 32'hxxxxxxxx;
        end else begin
            w  = txq.pop_front();
            lo = lowq.pop_front();
            bi = bitq.pop_front();
            chk({tag, "_lowlen"}, 64'(lo), 64'd128);
            chk({tag, "_bits"}, 64'(bi), 64'd32);
        end
    endtask

    // Spec rule: pixel(d,r,c) = frame[64d+8r+c]; plain digit k = row k-1, transposed digit k = column 8-k top to bottom.
    function automatic logic [7:0] digit_of(input logic [127:0] f, input int d, input int k);
        logic [7:0] v;
`ifdef SC_MAX7219CHAIN_TRANSPOSE_EN
        for (int r = 0; r < 8; r++) v[7 - r] = f[64 * d + 8 * r + (8 - k)];
`else
        for (int c = 0; c < 8; c++) v[c] = f[64 * d + 8 * (k - 1) + c];
`endif
        return v;
    endfunction

    function automatic logic [31:0] model_word(input logic [127:0] f, input int k);
        return {8'(k), digit_of(f, 1, k), 8'(k), digit_of(f, 0, k)};
    endfunction

    logic [3:0] last_sent;

    // One refresh pass against snapshot `cur`, with mid-pass frame/intensity changes after chosen digits.
    task automatic run_pass(input logic [127:0] cur, input logic [127:0] nxt, input int f_at,
                            input logic [3:0] ia, input int ia_at, input logic [3:0] ib, input int ib_at);
        logic [31:0] w;
        int fd0;
        fd0 = fd_cnt;
        for (int k = 1; k <= 8; k++) begin
            get_tx($sformatf("digit%0d", k), w);
            chk($sformatf("digit%0d_word", k), 64'(w), 64'(model_word(cur, k)));
            if (k == 8) chk("init_done_hold", 64'(init_done), 64'd1);
            @(negedge clk);
            if (k == f_at) frame = nxt;
            if (k == ia_at) intensity = ia;
            if (k == ib_at) intensity = ib;
        end
        chk("frame_done_count", 64'(fd_cnt - fd0), 64'd1);
        if (intensity != last_sent) begin
            get_tx("inten", w);
            chk("inten_word", 64'(w), 64'({8'h0A, 4'h0, intensity, 8'h0A, 4'h0, intensity}));
            last_sent = intensity;
        end
    endtask

    task automatic run_init(input logic [3:0] inten);
        logic [31:0] w;
        logic [31:0] exp_w [5];
        exp_w[0] = 32'h0C010C01;
        exp_w[1] = 32'h0F000F00;
        exp_w[2] = 32'h09000900;
        exp_w[3] = 32'h0B070B07;
        exp_w[4] = {8'h0A, 4'h0, inten, 8'h0A, 4'h0, inten};
        for (int i = 0; i < 5; i++) begin
            get_tx($sformatf("init%0d", i), w);
            chk($sformatf("init%0d_word", i), 64'(w), 64'(exp_w[i]));
            chk($sformatf("init%0d_done", i), 64'(init_done), (i == 4) ? 64'd1 : 64'd0);
        end
        last_sent = inten;
    endtask

    logic [127:0] f1, f2, f3, f4, fcur, fnext;
    int           n;
    int           bad;
    logic [3:0]   ni;

    initial begin
        rst       = 1'b1;
        frame     = 128'h0;
        intensity = 4'hA;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_din", 64'(din), 64'd0);
        chk("rst_ncs", 64'(ncs), 64'd1);
        chk("rst_clk", 64'(sclk), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);

        f1 = 128'h0;
        f1[64 +: 8] = 8'h81;
        f1[0 +: 8]  = 8'h3C;
        f2 = {$urandom, $urandom, $urandom, $urandom};
        f3 = 128'h0;
        f3[0 +: 8]  = 8'h80;
        f3[64 +: 8] = 8'h01;
        f4 = {$urandom, $urandom, $urandom, $urandom};
        frame = f1;

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ncs_first_fall", 64'(ncs), 64'd0);

        run_init(4'hA);
        run_pass(f1, f2, 1, 4'hA, -1, 4'hA, -1);
        run_pass(f2, f3, 4, 4'h3, 3, 4'h3, -1);
        run_pass(f3, f4, 6, 4'h5, 2, 4'h3, 5);
        fcur = f4;
        for (int p = 0; p < 4; p++) begin
            fnext = {$urandom, $urandom, $urandom, $urandom};
            ni = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : intensity;
            run_pass(fcur, fnext, $urandom_range(1, 7), 4'($urandom_range(0, 15)), $urandom_range(1, 3),
                     ni, $urandom_range(4, 7));
            fcur = fnext;
        end

        // Abort during bit 9 of the next transaction.
        n = 0;
        while (!(ncs == 1'b0 && sclk == 1'b0 && mon_bits == 8) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bit9_reached", 64'(mon_bits), 64'd8);
        rst = 1'b1;
        #1;
        chk("abort_ncs", 64'(ncs), 64'd1);
        chk("abort_clk", 64'(sclk), 64'd0);
        chk("abort_din", 64'(din), 64'd0);
        chk("abort_init_done", 64'(init_done), 64'd0);
        intensity = 4'h6;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_init(4'h6);

        bad = 0;
        foreach (gapq[i]) if (gapq[i] != 2) bad++;
        chk("gap_bad_count", 64'(bad), 64'd0);
        chk("gap_seen", 64'(gapq.size() > 10), 64'd1);
        chk("din_change_while_high", 64'(viol), 64'd0);
        chk("frame_done_misplaced", 64'(fd_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
